// File: rtl/count_seq_ctrl.sv
// Sequencing controller for a loadable up-counter: start/stop, programmable range,
// one-shot or periodic mode, terminal-count pulse and saturating terminal-count tally.
module count_seq_ctrl #(
   parameter int CW = 4,
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stop,
   input  logic          periodic,
   input  logic [CW-1:0] start_val,
   input  logic [CW-1:0] end_val,
   input  logic [CW-1:0] cnt_in,
   output logic          ld,
   output logic [CW-1:0] ldvalue,
   output logic          tc,
   output logic          busy,
   output logic          done,
   output logic [TW-1:0] tc_count
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] sv, ev;
   logic          pm;
   logic          accept;
   logic          at_end;

   // LOAD is a fixed one-cycle step, so a start seen there is not accepted
   assign accept = start & ~stop & (state != LOAD);
   assign at_end = (cnt_in == ev);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = LOAD;
         LOAD: state_nx = RUN;
         RUN: begin
            if (stop)        state_nx = IDLE;
            else if (start)  state_nx = LOAD;
            else if (at_end) state_nx = pm ? RUN : DONE;
         end
         DONE: begin
            if (stop)       state_nx = IDLE;
            else if (start) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Default is "hold": the counter reloads its own value and stays frozen
   always_comb begin
      ld      = 1'b1;
      ldvalue = cnt_in;
      tc      = 1'b0;
      case (state)
         LOAD: ldvalue = sv;
         RUN: begin
            if (!stop && !start) begin
               if (at_end) begin
                  tc = 1'b1;
                  if (pm) ldvalue = sv;
               end else begin
                  ld = 1'b0;
               end
            end
         end
         default: ;
      endcase
   end

   assign busy = (state == LOAD) || (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sv <= '0;
         ev <= '0;
         pm <= 1'b0;
      end else if (accept) begin
         sv <= start_val;
         ev <= end_val;
         pm <= periodic;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        tc_count <= '0;
      else if (accept)                tc_count <= '0;
      else if (tc && tc_count != '1)  tc_count <= tc_count + TW'(1);
   end

endmodule
